// File: rtl/sched_multi_ch.sv
// Multi-channel spike event scheduler.
// Each event source owns a circular FIFO (sched_ch_fifo, one instance per
// channel). A fixed-priority or round-robin arbiter feeds a single registered
// output word. Channels flagged in OPEN_LOOP_MASK are muted while the
// synchronised open-loop bit is set. Pushes that hit a full FIFO are counted
// in a saturating drop counter.
//
// Ports
//   CLK, RST             clock, synchronous active-high reset
//   CTRL_SCHED_EVENT_IN  per-channel push strobe
//   CTRL_SCHED_VIRTS     per-channel 2-bit tag, ch i at [2i+1:2i]
//   CTRL_SCHED_ADDR      per-channel event address
//   CTRL_SCHED_POP_N     active-low pop of the output word
//   CTRL_SCHED_FLUSH     clear every FIFO and the output word
//   SPI_OPEN_LOOP        open-loop mode, asynchronous to CLK
//   SCHED_EMPTY          output word not valid
//   SCHED_FULL           per-channel FIFO full
//   SCHED_DATA_OUT       {virts, addr} of the current output word
//   SCHED_CH_OUT         source channel of SCHED_DATA_OUT
//   SCHED_DROP_CNT       saturating count of pushes lost to a full FIFO

// Per-channel circular FIFO. push_i/pop_i arrive already qualified
// (never push when full, never pop when empty).
module sched_ch_fifo #(
    parameter int DW    = 12,
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] head_o,
    output logic          empty_o,
    output logic          full_o
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the count decides what is visible.
    always_ff @(posedge CLK) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

module sched_multi_ch #(
    parameter int                NUM_CH              = 2,
    parameter int                CH_W                = 1,
    parameter int                PRE_NEUR_ADDR_WIDTH = 10,
    parameter int                AER_IN_WIDTH        = 12,
    parameter int                FIFO_DEPTH          = 128,
    parameter int                FIFO_ADDR           = 7,
    parameter int                ARB_MODE            = 0,
    parameter logic [NUM_CH-1:0] OPEN_LOOP_MASK      = 2'b10,
    parameter int                DROP_CNT_WIDTH      = 16
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [NUM_CH-1:0]                     CTRL_SCHED_EVENT_IN,
    input  logic [2*NUM_CH-1:0]                   CTRL_SCHED_VIRTS,
    input  logic [NUM_CH*PRE_NEUR_ADDR_WIDTH-1:0] CTRL_SCHED_ADDR,
    input  logic                                  CTRL_SCHED_POP_N,
    input  logic                                  CTRL_SCHED_FLUSH,
    input  logic                                  SPI_OPEN_LOOP,
    output logic                                  SCHED_EMPTY,
    output logic [NUM_CH-1:0]                     SCHED_FULL,
    output logic [AER_IN_WIDTH-1:0]               SCHED_DATA_OUT,
    output logic [CH_W-1:0]                       SCHED_CH_OUT,
    output logic [DROP_CNT_WIDTH-1:0]             SCHED_DROP_CNT
);
    logic [1:0]                             ol_sync_q;
    logic [NUM_CH-1:0]                      req, wr_en, drop, full, ne, fifo_pop;
    logic [NUM_CH-1:0][AER_IN_WIDTH-1:0]    head;
    logic                                   gnt_vld, pop, load;
    logic [CH_W-1:0]                        gnt_idx;
    logic                                   valid_q, valid_d;
    logic [AER_IN_WIDTH-1:0]                data_q, data_d;
    logic [CH_W-1:0]                        ch_q, ch_d, rr_q, rr_d;
    logic [DROP_CNT_WIDTH-1:0]              drop_cnt_q, drop_cnt_d;
    logic [DROP_CNT_WIDTH:0]                ndrop, drop_sum;

    // Muted channels never reach the FIFO and are not counted as drops.
    assign req   = CTRL_SCHED_EVENT_IN & ~({NUM_CH{ol_sync_q[1]}} & OPEN_LOOP_MASK);
    assign wr_en = req & ~full & {NUM_CH{~CTRL_SCHED_FLUSH}};
    assign drop  = req &  full & {NUM_CH{~CTRL_SCHED_FLUSH}};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sched_ch_fifo #(
            .DW    (AER_IN_WIDTH),
            .DEPTH (FIFO_DEPTH),
            .AW    (FIFO_ADDR)
        ) u_fifo (
            .CLK     (CLK),
            .RST     (RST),
            .flush_i (CTRL_SCHED_FLUSH),
            .push_i  (wr_en[i]),
            .pop_i   (fifo_pop[i]),
            .wdata_i ({CTRL_SCHED_VIRTS[2*i +: 2],
                       CTRL_SCHED_ADDR[i*PRE_NEUR_ADDR_WIDTH +: PRE_NEUR_ADDR_WIDTH]}),
            .head_o  (head[i]),
            .empty_o (),
            .full_o  (full[i])
        );
        assign ne[i]       = ~g_ch[i].u_fifo.empty_o;
        assign fifo_pop[i] = load & (gnt_idx == CH_W'(i));
    end

    // Round-robin: first search channels above the pointer, then wrap to the
    // lowest non-empty one (which may be the pointer itself). Fixed priority
    // uses only the wrap pass.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (ARB_MODE == 1) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!gnt_vld && ne[i] && (CH_W'(i) > rr_q)) begin
                    gnt_vld = 1'b1;
                    gnt_idx = CH_W'(i);
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_vld && ne[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = CH_W'(i);
            end
        end
    end

    assign pop  = ~CTRL_SCHED_POP_N & valid_q;
    assign load = (~valid_q | pop) & gnt_vld & ~CTRL_SCHED_FLUSH;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        rr_d    = rr_q;
        if (CTRL_SCHED_FLUSH) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = head[gnt_idx];
            ch_d    = gnt_idx;
            if (ARB_MODE == 1) rr_d = gnt_idx;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        ndrop = '0;
        for (int i = 0; i < NUM_CH; i++)
            ndrop = ndrop + {{DROP_CNT_WIDTH{1'b0}}, drop[i]};
        drop_sum   = {1'b0, drop_cnt_q} + ndrop;
        drop_cnt_d = drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ol_sync_q  <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            ch_q       <= '0;
            rr_q       <= CH_W'(NUM_CH-1);
            drop_cnt_q <= '0;
        end else begin
            ol_sync_q  <= {ol_sync_q[0], SPI_OPEN_LOOP};
            valid_q    <= valid_d;
            data_q     <= data_d;
            ch_q       <= ch_d;
            rr_q       <= rr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign SCHED_EMPTY    = ~valid_q;
    assign SCHED_FULL     = full;
    assign SCHED_DATA_OUT = data_q;
    assign SCHED_CH_OUT   = ch_q;
    assign SCHED_DROP_CNT = drop_cnt_q;
endmodule

// File: tb/tb_sched_multi_ch.sv
// Bench for sched_multi_ch: one fixed-priority and one round-robin instance
// share all inputs. Expected {ch, data} words go into a queue per instance;
// a negedge monitor pops and compares whenever a word is consumed.
module tb_sched_multi_ch;
    logic        CLK = 1'b0;
    logic        RST, POP_N, FLUSH, OL;
    logic [1:0]  EV;
    logic [3:0]  VIRTS;
    logic [19:0] ADDR;

    logic        e0, e1;
    logic [1:0]  f0, f1;
    logic [11:0] d0, d1;
    logic        c0, c1;
    logic [15:0] dc0, dc1;

    int checks = 0;
    int failures = 0;
    logic [12:0] q0[$];
    logic [12:0] q1[$];
    logic [12:0] exp0, exp1;

    always #5 CLK = ~CLK;

    sched_multi_ch #(.ARB_MODE(0)) u0 (
        .CLK(CLK), .RST(RST), .CTRL_SCHED_EVENT_IN(EV), .CTRL_SCHED_VIRTS(VIRTS),
        .CTRL_SCHED_ADDR(ADDR), .CTRL_SCHED_POP_N(POP_N), .CTRL_SCHED_FLUSH(FLUSH),
        .SPI_OPEN_LOOP(OL), .SCHED_EMPTY(e0), .SCHED_FULL(f0), .SCHED_DATA_OUT(d0),
        .SCHED_CH_OUT(c0), .SCHED_DROP_CNT(dc0));

    sched_multi_ch #(.ARB_MODE(1)) u1 (
        .CLK(CLK), .RST(RST), .CTRL_SCHED_EVENT_IN(EV), .CTRL_SCHED_VIRTS(VIRTS),
        .CTRL_SCHED_ADDR(ADDR), .CTRL_SCHED_POP_N(POP_N), .CTRL_SCHED_FLUSH(FLUSH),
        .SPI_OPEN_LOOP(OL), .SCHED_EMPTY(e1), .SCHED_FULL(f1), .SCHED_DATA_OUT(d1),
        .SCHED_CH_OUT(c1), .SCHED_DROP_CNT(dc1));

    // Scoreboard monitor: a word is consumed when valid and POP_N is low.
    always @(negedge CLK) begin
        if (!RST && !FLUSH && !POP_N && !e0) begin
            checks++;
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL sb0 unexpected word act=%h", {c0, d0});
            end else begin
                exp0 = q0.pop_front();
                if ({c0, d0} !== exp0) begin
                    failures++;
                    $display("FAIL sb0 word act=%h exp=%h", {c0, d0}, exp0);
                end
            end
        end
        if (!RST && !FLUSH && !POP_N && !e1) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL sb1 unexpected word act=%h", {c1, d1});
            end else begin
                exp1 = q1.pop_front();
                if ({c1, d1} !== exp1) begin
                    failures++;
                    $display("FAIL sb1 word act=%h exp=%h", {c1, d1}, exp1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ev, input logic [1:0] v1, input logic [9:0] a1,
                         input logic [1:0] v0, input logic [9:0] a0);
        EV    = ev;
        VIRTS = {v1, v0};
        ADDR  = {a1, a0};
    endtask

    task automatic sb_push(input logic [12:0] w0, input logic [12:0] w1);
        q0.push_back(w0);
        q1.push_back(w1);
    endtask

    // Pop continuously until both scoreboards drain and both outputs go empty.
    task automatic drain(input string nm, input int budget);
        int n = 0;
        POP_N = 1'b0;
        while ((q0.size() != 0 || q1.size() != 0 || !e0 || !e1) && n < budget) begin
            tick();
            n++;
        end
        chk(nm, {31'd0, (q0.size() == 0 && q1.size() == 0 && e0 && e1)}, 32'd1);
    endtask

    task automatic reset_dut();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        tick();
    endtask

    initial begin
        RST = 1'b1; POP_N = 1'b1; FLUSH = 1'b0; OL = 1'b0;
        drive(2'b00, 2'd0, 10'd0, 2'd0, 10'd0);

        // T1 reset values
        tick(); tick();
        chk("rst_empty", {31'd0, e0}, 32'd1);
        chk("rst_full",  {30'd0, f0}, 32'd0);
        chk("rst_drop",  {16'd0, dc0}, 32'd0);
        chk("rst_data",  {20'd0, d0}, 32'd0);
        chk("rst_ch",    {31'd0, c0}, 32'd0);
        RST = 1'b0;
        tick();

        // T2 latency and order on ch0, continuous pop
        POP_N = 1'b0;
        drive(2'b01, 2'd0, 10'd0, 2'b01, 10'h001); sb_push(13'h0401, 13'h0401);
        tick();
        chk("t2_no_bypass", {31'd0, e0}, 32'd1);
        drive(2'b01, 2'd0, 10'd0, 2'b10, 10'h002); sb_push(13'h0802, 13'h0802);
        tick();
        chk("t2_word1", {19'd0, c0, d0}, 32'h0401);
        drive(2'b01, 2'd0, 10'd0, 2'b11, 10'h003); sb_push(13'h0C03, 13'h0C03);
        tick();
        chk("t2_word2", {19'd0, c0, d0}, 32'h0802);
        drive(2'b00, 2'd0, 10'd0, 2'd0, 10'd0);
        tick();
        chk("t2_word3", {19'd0, c0, d0}, 32'h0C03);
        tick();
        chk("t2_empty_after", {31'd0, e0}, 32'd1);
        drain("t2_drain", 10);

        // T3 fill ch1: 1 word in output + 128 in FIFO, 130th push dropped
        POP_N = 1'b1;
        for (int i = 0; i < 130; i++) begin
            drive(2'b10, 2'(i), 10'(i), 2'd0, 10'd0);
            if (i < 129) sb_push({1'b1, 2'(i), 10'(i)}, {1'b1, 2'(i), 10'(i)});
            tick();
            if (i == 127) chk("t3_not_full_yet", {30'd0, f0}, 32'd0);
            if (i == 128) begin
                chk("t3_full", {30'd0, f0}, 32'd2);
                chk("t3_no_drop_yet", {16'd0, dc0}, 32'd0);
            end
        end
        drive(2'b00, 2'd0, 10'd0, 2'd0, 10'd0);
        chk("t3_drop", {16'd0, dc0}, 32'd1);
        chk("t3_drop_rr", {16'd0, dc1}, 32'd1);
        drain("t3_drain", 300);
        chk("t3_full_clear", {30'd0, f0}, 32'd0);

        // T6a flush with 10 events queued and a push on ch0 in the flush cycle
        POP_N = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(2'b11, 2'd1, 10'(10'h2A0 + k), 2'd2, 10'(10'h150 + k));
            tick();
        end
        FLUSH = 1'b1;
        drive(2'b01, 2'd0, 10'd0, 2'd3, 10'h3FF);
        tick();
        FLUSH = 1'b0;
        drive(2'b00, 2'd0, 10'd0, 2'd0, 10'd0);
        chk("t6_flush_empty", {31'd0, e0}, 32'd1);
        chk("t6_flush_full",  {30'd0, f0}, 32'd0);
        chk("t6_flush_drop",  {16'd0, dc0}, 32'd1);
        tick(); tick();
        chk("t6_flush_push_lost", {31'd0, e0}, 32'd1);
        chk("t6_flush_push_lost_rr", {31'd0, e1}, 32'd1);

        // T4 arbitration after a fresh reset
        reset_dut();
        chk("t4_drop_reset", {16'd0, dc0}, 32'd0);
        POP_N = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 2'd0, 10'(10'h200 + k), 2'd0, 10'(10'h100 + k));
            tick();
        end
        drive(2'b00, 2'd0, 10'd0, 2'd0, 10'd0);
        for (int k = 0; k < 4; k++) q0.push_back({1'b0, 2'd0, 10'(10'h100 + k)});
        for (int k = 0; k < 4; k++) q0.push_back({1'b1, 2'd0, 10'(10'h200 + k)});
        for (int k = 0; k < 4; k++) begin
            q1.push_back({1'b0, 2'd0, 10'(10'h100 + k)});
            q1.push_back({1'b1, 2'd0, 10'(10'h200 + k)});
        end
        drain("t4_drain", 30);

        // T5 open loop: ch1 muted while synchronised bit is set
        POP_N = 1'b0;
        OL = 1'b1;
        tick(); tick(); tick();
        drive(2'b11, 2'b11, 10'h0AA, 2'd0, 10'h055);
        sb_push(13'h0055, 13'h0055);
        tick();
        drive(2'b00, 2'd0, 10'd0, 2'd0, 10'd0);
        drain("t5_ol_drain", 10);
        chk("t5_ol_no_drop", {16'd0, dc0}, 32'd0);
        OL = 1'b0;
        tick(); tick(); tick();
        drive(2'b10, 2'b11, 10'h0BB, 2'd0, 10'd0);
        sb_push(13'h1CBB, 13'h1CBB);
        tick();
        drive(2'b00, 2'd0, 10'd0, 2'd0, 10'd0);
        drain("t5_ch1_back", 10);

        // T6b reset mid-stream
        POP_N = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(2'b11, 2'd1, 10'(10'h1F0 + k), 2'd3, 10'(10'h3F0 + k));
            tick();
        end
        chk("t6_pre_reset_valid", {31'd0, e0}, 32'd0);
        RST = 1'b1;
        drive(2'b01, 2'd0, 10'd0, 2'd2, 10'h111);
        tick();
        RST = 1'b0;
        drive(2'b00, 2'd0, 10'd0, 2'd0, 10'd0);
        chk("t6_rst_empty", {31'd0, e0}, 32'd1);
        chk("t6_rst_full",  {30'd0, f0}, 32'd0);
        chk("t6_rst_drop",  {16'd0, dc0}, 32'd0);
        chk("t6_rst_data",  {20'd0, d0}, 32'd0);
        chk("t6_rst_data_rr", {20'd0, d1}, 32'd0);
        chk("t6_rst_ch",    {31'd0, c0}, 32'd0);
        tick(); tick();
        chk("t6_rst_stays_empty", {31'd0, e0}, 32'd1);

        chk("sb0_left", q0.size(), 32'd0);
        chk("sb1_left", q1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
